sram_responder: RTL and testbench

//  Synthesizable device-side responder for the 16-bit asynchronous-SRAM pin interface that the memory-stage SRAM

---
 rtl/sram_resp_pkg.sv | 25 ++
 rtl/sram_responder_if.sv | 41 ++++
 rtl/sram_resp_array.sv | 37 +++
 rtl/sram_responder.sv | 158 +++++++++++++++
 tb/tb_sram_responder.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/sram_resp_pkg.sv
// sram_resp_pkg: shared definitions for the SRAM pin-level responder.
//   - state_e     : responder FSM encoding (IDLE=0, READ_WAIT=1, READ_DRIVE=2)
//   - LANE_HI/LO  : byte-lane indices into the 2-bit lane-enable vectors
//   - LAT_W       : width of the read wait-state counter
//   - `SRAM_RESP_LAT_LEGAL(lat) : true when a READ_LAT value is in 1..15
`ifndef SRAM_RESP_PKG_SV
`define SRAM_RESP_PKG_SV

`define SRAM_RESP_LAT_LEGAL(lat) (((lat) >= 1) && ((lat) <= 15))

package sram_resp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_READ_WAIT  = 2'd1,
      ST_READ_DRIVE = 2'd2
   } state_e;

   localparam int LANE_LO = 0;
   localparam int LANE_HI = 1;
   localparam int LAT_W   = 4;

endpackage

`endif

// File: rtl/sram_responder_if.sv
// sram_responder_if: asynchronous-SRAM pin bundle shared by a controller
// (master) and the responder (slave).
//   SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N : master -> slave
//   SRAM_DQ  : resolved 16-bit bidirectional data bus
//   dq_m_out/dq_m_oe : master's per-lane DQ driver (value, lane enables)
//   dq_s_out/dq_s_oe : slave's per-lane DQ driver (value, lane enables)
// Both tristate drivers are resolved here so SRAM_DQ has a single owner.
interface sram_responder_if #(
   parameter int ADDR_W = 18
);
   logic [ADDR_W-1:0] SRAM_ADDR;
   logic              SRAM_UB_N;
   logic              SRAM_LB_N;
   logic              SRAM_WE_N;
   logic              SRAM_CE_N;
   logic              SRAM_OE_N;

   logic [15:0]       dq_m_out;
   logic [1:0]        dq_m_oe;
   logic [15:0]       dq_s_out;
   logic [1:0]        dq_s_oe;

   wire  [15:0]       SRAM_DQ;

   assign SRAM_DQ[15:8] = dq_m_oe[1] ? dq_m_out[15:8] : 8'hzz;
   assign SRAM_DQ[7:0]  = dq_m_oe[0] ? dq_m_out[7:0]  : 8'hzz;
   assign SRAM_DQ[15:8] = dq_s_oe[1] ? dq_s_out[15:8] : 8'hzz;
   assign SRAM_DQ[7:0]  = dq_s_oe[0] ? dq_s_out[7:0]  : 8'hzz;

   modport master (
      output SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N,
      output dq_m_out, dq_m_oe,
      input  SRAM_DQ, dq_s_oe
   );

   modport slave (
      input  SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N,
      input  SRAM_DQ,
      output dq_s_out, dq_s_oe
   );
endinterface

// File: rtl/sram_resp_array.sv
// sram_resp_array: 2**DEPTH_LOG2 x 16 storage with independent byte-lane write
// enables and one registered read port (block-RAM friendly, no reset on data).
//   clk      : rising-edge clock
//   we_hi/lo : write enables for bits [15:8] / [7:0]
//   waddr    : write word index, wdata : write data
//   rd_en    : capture mem[raddr] into rdata on this edge
//   rdata    : registered read data
module sram_resp_array #(
   parameter int DEPTH_LOG2 = 12
) (
   input  logic                  clk,
   input  logic                  we_hi,
   input  logic                  we_lo,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  logic [15:0]           wdata,
   input  logic                  rd_en,
   input  logic [DEPTH_LOG2-1:0] raddr,
   output logic [15:0]           rdata
);
   logic [15:0] mem_q [0:(2**DEPTH_LOG2)-1];
   logic [15:0] rdata_q;

   // Byte-masked write and synchronous read.
   always_ff @(posedge clk) begin
      if (we_hi) begin
         mem_q[waddr][15:8] <= wdata[15:8];
      end
      if (we_lo) begin
         mem_q[waddr][7:0] <= wdata[7:0];
      end
      if (rd_en) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/sram_responder.sv
// sram_responder: device-side model of a 16-bit asynchronous SRAM. Samples the
// control pins every clk, stores byte-masked writes, returns read data after
// READ_LAT wait states, counts transactions and flags DQ contention.
//   clk, rst     : clock, synchronous active-high reset (memory is not cleared)
//   bus          : SRAM pin bundle (slave modport)
//   rd_count     : reads completed, 16-bit wrapping
//   wr_count     : write strobes accepted, 16-bit wrapping
//   bus_conflict : sticky, WE_N seen low while the responder was driving DQ
module sram_responder
   import sram_resp_pkg::*;
#(
   parameter int ADDR_W     = 18,
   parameter int DATA_W     = 16,
   parameter int DEPTH_LOG2 = 12,
   parameter int READ_LAT   = 2
) (
   input  logic              clk,
   input  logic              rst,
   sram_responder_if.slave   bus,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count,
   output logic              bus_conflict
);
   if (!`SRAM_RESP_LAT_LEGAL(READ_LAT)) begin : g_bad_lat
      $error("sram_responder: READ_LAT must be within 1..15");
   end
   if (DATA_W != 16) begin : g_bad_width
      $error("sram_responder: DATA_W must be 16");
   end

   localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(READ_LAT - 1);

   state_e              state_q, state_d;
   logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
   logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
   logic [15:0]         rd_count_q, rd_count_d;
   logic [15:0]         wr_count_q, wr_count_d;
   logic                prev_wr_q, prev_wr_d;
   logic                bus_conflict_q, bus_conflict_d;

   logic                wr_s, rd_s, addr_chg_s, rd_en_s;
   logic [DATA_W-1:0]   dout_s;
   logic [1:0]          lane_oe_s;

   // Pin decode: WE_N low takes priority over OE_N low.
   assign wr_s       = !bus.SRAM_CE_N && !bus.SRAM_WE_N;
   assign rd_s       = !bus.SRAM_CE_N &&  bus.SRAM_WE_N && !bus.SRAM_OE_N;
   assign addr_chg_s = (bus.SRAM_ADDR != lat_addr_q);

   sram_resp_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
      .clk   (clk),
      .we_hi (wr_s && !bus.SRAM_UB_N && !rst),
      .we_lo (wr_s && !bus.SRAM_LB_N && !rst),
      .waddr (bus.SRAM_ADDR[DEPTH_LOG2-1:0]),
      .wdata (bus.SRAM_DQ),
      .rd_en (rd_en_s),
      .raddr (lat_addr_q[DEPTH_LOG2-1:0]),
      .rdata (dout_s)
   );

   // Next-state: a write aborts any read; otherwise walk IDLE -> WAIT -> DRIVE.
   always_comb begin
      state_d        = state_q;
      lat_cnt_d      = lat_cnt_q;
      lat_addr_d     = lat_addr_q;
      rd_count_d     = rd_count_q;
      wr_count_d     = wr_count_q;
      prev_wr_d      = wr_s;
      bus_conflict_d = bus_conflict_q ||
                       (!bus.SRAM_WE_N && (state_q == ST_READ_DRIVE));
      rd_en_s        = 1'b0;

      if (wr_s) begin
         state_d = ST_IDLE;
         // One count per strobe, however long WE_N is held.
         if (!prev_wr_q) begin
            wr_count_d = wr_count_q + 16'd1;
         end else begin
            wr_count_d = wr_count_q;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (rd_s) begin
                  lat_addr_d = bus.SRAM_ADDR;
                  lat_cnt_d  = LAT_RELOAD;
                  state_d    = ST_READ_WAIT;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_READ_WAIT: begin
               if (!rd_s) begin
                  state_d = ST_IDLE;
               end else if (addr_chg_s) begin
                  lat_addr_d = bus.SRAM_ADDR;
                  lat_cnt_d  = LAT_RELOAD;
               end else if (lat_cnt_q == {LAT_W{1'b0}}) begin
                  rd_en_s    = 1'b1;
                  rd_count_d = rd_count_q + 16'd1;
                  state_d    = ST_READ_DRIVE;
               end else begin
                  lat_cnt_d = lat_cnt_q - {{(LAT_W-1){1'b0}}, 1'b1};
               end
            end
            ST_READ_DRIVE: begin
               if (!rd_s) begin
                  state_d = ST_IDLE;
               end else if (addr_chg_s) begin
                  lat_addr_d = bus.SRAM_ADDR;
                  lat_cnt_d  = LAT_RELOAD;
                  state_d    = ST_READ_WAIT;
               end else begin
                  state_d = ST_READ_DRIVE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State, counter and flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         lat_cnt_q      <= {LAT_W{1'b0}};
         lat_addr_q     <= {ADDR_W{1'b0}};
         rd_count_q     <= 16'd0;
         wr_count_q     <= 16'd0;
         prev_wr_q      <= 1'b0;
         bus_conflict_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         lat_cnt_q      <= lat_cnt_d;
         lat_addr_q     <= lat_addr_d;
         rd_count_q     <= rd_count_d;
         wr_count_q     <= wr_count_d;
         prev_wr_q      <= prev_wr_d;
         bus_conflict_q <= bus_conflict_d;
      end
   end

   // Lane enables follow UB_N/LB_N combinationally so a lane can be released
   // mid-read without a state change.
   always_comb begin
      lane_oe_s          = 2'b00;
      lane_oe_s[LANE_HI] = (state_q == ST_READ_DRIVE) && !bus.SRAM_UB_N;
      lane_oe_s[LANE_LO] = (state_q == ST_READ_DRIVE) && !bus.SRAM_LB_N;
   end

   assign bus.dq_s_oe  = lane_oe_s;
   assign bus.dq_s_out = dout_s;
   assign rd_count     = rd_count_q;
   assign wr_count     = wr_count_q;
   assign bus_conflict = bus_conflict_q;
endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: a vector table of writes/reads with
// hand-derived expected data, a scoreboard queue popped when the responder
// starts driving DQ, and hand-written multi-cycle corner sequences.
module tb_sram_responder;
   localparam int READ_LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] rd_count;
   logic [15:0] wr_count;
   logic        bus_conflict;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_rd  = 0;
   int exp_wr  = 0;

   typedef struct {
      logic [15:0] data;
      logic [1:0]  lanes;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      bit          is_wr;
      logic [17:0] addr;
      logic [15:0] data;
      logic        ub_n;
      logic        lb_n;
      int          hold;
      logic [1:0]  lanes;
   } vec_t;
   vec_t vecs[13];

   always #5 clk = ~clk;

   sram_responder_if #(.ADDR_W(18)) bus ();

   sram_responder #(
      .ADDR_W(18), .DATA_W(16), .DEPTH_LOG2(12), .READ_LAT(READ_LAT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .rd_count     (rd_count),
      .wr_count     (wr_count),
      .bus_conflict (bus_conflict)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic go_idle();
      bus.SRAM_CE_N = 1'b1;
      bus.SRAM_WE_N = 1'b1;
      bus.SRAM_OE_N = 1'b1;
      bus.SRAM_UB_N = 1'b1;
      bus.SRAM_LB_N = 1'b1;
      bus.dq_m_oe   = 2'b00;
   endtask

   task automatic do_write(input logic [17:0] addr, input logic [15:0] data,
                           input logic ub_n, input logic lb_n, input int hold);
      bus.SRAM_ADDR = addr;
      bus.dq_m_out  = data;
      bus.dq_m_oe   = 2'b11;
      bus.SRAM_UB_N = ub_n;
      bus.SRAM_LB_N = lb_n;
      bus.SRAM_OE_N = 1'b1;
      bus.SRAM_CE_N = 1'b0;
      bus.SRAM_WE_N = 1'b0;
      repeat (hold) @(negedge clk);
      go_idle();
      exp_wr++;
      @(negedge clk);
   endtask

   task automatic start_read(input logic [17:0] addr, input logic ub_n, input logic lb_n,
                             input logic [15:0] exp_data, input logic [1:0] exp_lanes);
      bus.SRAM_ADDR = addr;
      bus.SRAM_UB_N = ub_n;
      bus.SRAM_LB_N = lb_n;
      bus.dq_m_oe   = 2'b00;
      bus.SRAM_WE_N = 1'b1;
      bus.SRAM_OE_N = 1'b0;
      bus.SRAM_CE_N = 1'b0;
      sb_q.push_back('{data: exp_data, lanes: exp_lanes});
   endtask

   // Wait (bounded) for the responder to drive, then pop and compare.
   task automatic compare_drive(input string name, input int exp_lat);
      int  cyc;
      bit  got;
      sb_t e;
      cyc = 0;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         cyc++;
         if (bus.dq_s_oe != 2'b00) begin
            got = 1'b1;
            break;
         end
      end
      e = sb_q.pop_front();
      if (!got) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: no DQ drive within 20 cycles, expected data 0x%0h", name, e.data);
      end else begin
         exp_rd++;
         check({name, "_latency"}, cyc, exp_lat);
         check({name, "_lanes"}, bus.dq_s_oe, e.lanes);
         if (e.lanes[1]) check({name, "_hi"}, bus.SRAM_DQ[15:8], e.data[15:8]);
         if (e.lanes[0]) check({name, "_lo"}, bus.SRAM_DQ[7:0], e.data[7:0]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.SRAM_ADDR = 18'h0;
      bus.dq_m_out  = 16'h0;
      go_idle();

      // Table: writes and reads with hand-computed read results.
      vecs[0]  = '{1'b1, 18'h00010, 16'hBEEF, 1'b0, 1'b0, 4, 2'b00};
      vecs[1]  = '{1'b0, 18'h00010, 16'hBEEF, 1'b0, 1'b0, 0, 2'b11};
      vecs[2]  = '{1'b1, 18'h00020, 16'h1234, 1'b0, 1'b0, 1, 2'b00};
      vecs[3]  = '{1'b1, 18'h00020, 16'hAB55, 1'b1, 1'b0, 1, 2'b00};
      vecs[4]  = '{1'b0, 18'h00020, 16'h1255, 1'b0, 1'b0, 0, 2'b11};
      vecs[5]  = '{1'b0, 18'h00020, 16'h1200, 1'b0, 1'b1, 0, 2'b10};
      vecs[6]  = '{1'b1, 18'h01005, 16'h0F0F, 1'b0, 1'b0, 2, 2'b00};
      vecs[7]  = '{1'b0, 18'h00005, 16'h0F0F, 1'b0, 1'b0, 0, 2'b11};
      vecs[8]  = '{1'b1, 18'h3F123, 16'h5AA5, 1'b0, 1'b0, 1, 2'b00};
      vecs[9]  = '{1'b0, 18'h00123, 16'h5AA5, 1'b0, 1'b0, 0, 2'b11};
      vecs[10] = '{1'b1, 18'h00123, 16'h77C3, 1'b1, 1'b1, 1, 2'b00};
      vecs[11] = '{1'b0, 18'h00123, 16'h5AA5, 1'b0, 1'b0, 0, 2'b11};
      vecs[12] = '{1'b0, 18'h00010, 16'h00EF, 1'b1, 1'b0, 0, 2'b01};

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_dq_oe", bus.dq_s_oe, 2'b00);
      check("rst_rd_count", rd_count, 16'd0);
      check("rst_wr_count", wr_count, 16'd0);
      check("rst_conflict", bus_conflict, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 13; i++) begin
         if (vecs[i].is_wr) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].ub_n, vecs[i].lb_n, vecs[i].hold);
         end else begin
            start_read(vecs[i].addr, vecs[i].ub_n, vecs[i].lb_n, vecs[i].data, vecs[i].lanes);
            compare_drive($sformatf("vec%0d", i), READ_LAT + 1);
            go_idle();
            @(negedge clk);
            check($sformatf("vec%0d_release", i), bus.dq_s_oe, 2'b00);
         end
         if (i == 1) begin
            check("first_wr_count", wr_count, 16'd1);
            check("first_rd_count", rd_count, 16'd1);
         end
      end
      check("table_wr_count", wr_count, exp_wr[15:0]);
      check("table_rd_count", rd_count, exp_rd[15:0]);
      check("table_conflict", bus_conflict, 1'b0);

      // Address change during READ_WAIT restarts the latency.
      start_read(18'h00010, 1'b0, 1'b0, 16'h1255, 2'b11);
      @(negedge clk);
      bus.SRAM_ADDR = 18'h00020;
      compare_drive("addr_chg", READ_LAT + 1);

      // OE_N high while driving releases DQ on the next edge.
      bus.SRAM_OE_N = 1'b1;
      @(negedge clk);
      check("oe_release", bus.dq_s_oe, 2'b00);
      go_idle();
      @(negedge clk);

      // WE_N low while driving sets the sticky conflict flag.
      start_read(18'h00010, 1'b0, 1'b0, 16'hBEEF, 2'b11);
      compare_drive("pre_conflict", READ_LAT + 1);
      bus.SRAM_WE_N = 1'b0;
      exp_wr++;
      @(negedge clk);
      check("conflict_set", bus_conflict, 1'b1);
      check("conflict_release", bus.dq_s_oe, 2'b00);
      go_idle();
      repeat (3) @(negedge clk);
      check("conflict_sticky", bus_conflict, 1'b1);
      check("conflict_wr_count", wr_count, exp_wr[15:0]);
      check("conflict_rd_count", rd_count, exp_rd[15:0]);

      // Reset during READ_DRIVE; a write in a reset cycle is dropped.
      start_read(18'h00010, 1'b0, 1'b0, 16'hBEEF, 2'b11);
      compare_drive("pre_reset", READ_LAT + 1);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_dq_oe", bus.dq_s_oe, 2'b00);
      check("midrst_rd_count", rd_count, 16'd0);
      check("midrst_wr_count", wr_count, 16'd0);
      check("midrst_conflict", bus_conflict, 1'b0);
      bus.SRAM_OE_N = 1'b1;
      bus.dq_m_out  = 16'h2222;
      bus.dq_m_oe   = 2'b11;
      bus.SRAM_WE_N = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      go_idle();
      @(negedge clk);
      exp_rd = 0;
      exp_wr = 0;
      start_read(18'h00010, 1'b0, 1'b0, 16'hBEEF, 2'b11);
      compare_drive("retain", READ_LAT + 1);
      go_idle();
      @(negedge clk);
      check("post_rst_rd_count", rd_count, 16'd1);
      check("post_rst_wr_count", wr_count, 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
